// File: rtl/riscv_pkg.sv
// Shared opcode constants and loader/control FSM state encoding.
package riscv_pkg;

  localparam logic [6:0] OP_LOAD   = 7'h03;
  localparam logic [6:0] OP_STORE  = 7'h23;
  localparam logic [6:0] OP_BRANCH = 7'h63;
  localparam logic [6:0] OP_RTYPE  = 7'h33;
  localparam logic [6:0] OP_ITYPE  = 7'h13;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RECV  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/opcode_check.sv
// Combinational legality check of a 7-bit major opcode.
module opcode_check
  import riscv_pkg::*;
(
  input  logic [6:0] i_opcode,
  output logic       o_legal
);

  assign o_legal = (i_opcode == OP_LOAD)   || (i_opcode == OP_STORE) ||
                   (i_opcode == OP_BRANCH) || (i_opcode == OP_RTYPE) ||
                   (i_opcode == OP_ITYPE);

endmodule

// File: rtl/instr_loader.sv
// Assembles little-endian byte stream into 32-bit words and writes them to
// instruction memory, flagging the first word with an unsupported opcode.
module instr_loader
  import riscv_pkg::*;
#(
  parameter int unsigned DEPTH  = 64,
  parameter int unsigned ADDR_W = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W:0]   word_count,
  input  logic              abort,
  input  logic [7:0]        byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  output logic              we,
  output logic [ADDR_W-1:0] waddr,
  output logic [31:0]       wdata,
  output logic              busy,
  output logic              done,
  output logic              illegal,
  output logic [ADDR_W-1:0] illegal_addr
);

  localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W+1)'(DEPTH);

  state_t            r_state;
  logic [1:0]        r_byte_idx;
  logic [ADDR_W-1:0] r_word_idx;
  logic [ADDR_W:0]   r_count;
  logic [31:0]       r_wdata;
  logic              r_illegal;
  logic [ADDR_W-1:0] r_illegal_addr;

  logic              w_legal;
  logic              w_last;
  logic [ADDR_W:0]   w_count_clamped;

  opcode_check u_opcode_check (
    .i_opcode (r_wdata[6:0]),
    .o_legal  (w_legal)
  );

  assign w_count_clamped = (word_count > DEPTH_CNT) ? DEPTH_CNT : word_count;
  assign w_last          = ({1'b0, r_word_idx} == (r_count - 1'b1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state        <= ST_IDLE;
      r_byte_idx     <= '0;
      r_word_idx     <= '0;
      r_count        <= '0;
      r_wdata        <= '0;
      r_illegal      <= 1'b0;
      r_illegal_addr <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            if (word_count == '0) begin
              r_state <= ST_DONE;
            end else begin
              r_state        <= ST_RECV;
              r_count        <= w_count_clamped;
              r_byte_idx     <= '0;
              r_word_idx     <= '0;
              r_illegal      <= 1'b0;
              r_illegal_addr <= '0;
            end
          end
        end
        ST_RECV: begin
          if (abort) begin
            r_state <= ST_IDLE;
          end else if (byte_valid) begin
            r_wdata[{r_byte_idx, 3'b000} +: 8] <= byte_in;
            r_byte_idx <= r_byte_idx + 2'd1;
            if (r_byte_idx == 2'd3) begin
              r_state <= ST_WRITE;
            end
          end
        end
        ST_WRITE: begin
          if (abort) begin
            r_state <= ST_IDLE;
          end else begin
            // Only the first offending word records its address.
            if (!w_legal && !r_illegal) begin
              r_illegal      <= 1'b1;
              r_illegal_addr <= r_word_idx;
            end
            if (w_last) begin
              r_state <= ST_DONE;
            end else begin
              r_state    <= ST_RECV;
              r_word_idx <= r_word_idx + 1'b1;
              r_byte_idx <= '0;
            end
          end
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // A same-cycle abort must cancel the pending write, so we is gated combinationally.
  assign we           = (r_state == ST_WRITE) && !abort;
  assign byte_ready   = (r_state == ST_RECV);
  assign busy         = (r_state != ST_IDLE);
  assign done         = (r_state == ST_DONE);
  assign waddr        = r_word_idx;
  assign wdata        = r_wdata;
  assign illegal      = r_illegal;
  assign illegal_addr = r_illegal_addr;

endmodule

// File: tb/tb_instr_loader.sv
// Self-checking bench for instr_loader against a transaction-level model.
module tb_instr_loader;

  localparam int unsigned DEPTH  = 64;
  localparam int unsigned ADDR_W = 6;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic [ADDR_W:0]   word_count;
  logic              abort;
  logic [7:0]        byte_in;
  logic              byte_valid;
  logic              byte_ready;
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [31:0]       wdata;
  logic              busy;
  logic              done;
  logic              illegal;
  logic [ADDR_W-1:0] illegal_addr;

  instr_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .word_count   (word_count),
    .abort        (abort),
    .byte_in      (byte_in),
    .byte_valid   (byte_valid),
    .byte_ready   (byte_ready),
    .we           (we),
    .waddr        (waddr),
    .wdata        (wdata),
    .busy         (busy),
    .done         (done),
    .illegal      (illegal),
    .illegal_addr (illegal_addr)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  logic [ADDR_W-1:0] wq_addr[$];
  logic [31:0]       wq_data[$];
  int                done_cnt = 0;

  bit                exp_illegal  = 1'b0;
  logic [ADDR_W-1:0] exp_ill_addr = '0;

  always @(negedge clk) begin
    if (we) begin
      wq_addr.push_back(waddr);
      wq_data.push_back(wdata);
    end
    if (done) done_cnt++;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic bit is_legal(input logic [6:0] op);
    return (op == 7'h03) || (op == 7'h23) || (op == 7'h63) ||
           (op == 7'h33) || (op == 7'h13);
  endfunction

  function automatic logic [31:0] rand_word();
    logic [31:0] w;
    w = $urandom;
    if ($urandom_range(0, 3) != 0) begin
      case ($urandom_range(0, 4))
        0: w[6:0] = 7'h03;
        1: w[6:0] = 7'h23;
        2: w[6:0] = 7'h63;
        3: w[6:0] = 7'h33;
        default: w[6:0] = 7'h13;
      endcase
    end
    return w;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    wq_addr.delete();
    wq_data.delete();
    done_cnt = 0;
  endtask

  task automatic start_load(input int wc);
    start      = 1'b1;
    word_count = (ADDR_W+1)'(wc);
    tick();
    start = 1'b0;
    if (wc != 0) begin
      exp_illegal  = 1'b0;
      exp_ill_addr = '0;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    bit ok;
    ok = 1'b0;
    byte_valid = 1'b0;
    repeat (gap) tick();
    byte_valid = 1'b1;
    byte_in    = b;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      ok = byte_ready;
    end
    @(posedge clk);
    #1;
    byte_valid = 1'b0;
    if (!ok) chk("byte_ready_timeout", 64'(ok), 64'd1);
  endtask

  function automatic int pick_gap(input int mode);
    if (mode == 0) return 0;
    if (mode == 1) return 1;
    return $urandom_range(0, 2);
  endfunction

  task automatic send_word(input logic [31:0] w, input int mode);
    for (int k = 0; k < 4; k++) begin
      logic [7:0] b;
      b = w[8*k +: 8];
      send_byte(b, pick_gap(mode));
    end
  endtask

  task automatic check_writes(input int n, input logic [31:0] words[$]);
    chk("we_count", 64'(wq_data.size()), 64'(n));
    for (int i = 0; i < n && i < wq_data.size(); i++) begin
      chk("waddr", 64'(wq_addr[i]), 64'(i));
      chk("wdata", 64'(wq_data[i]), 64'(words[i]));
    end
  endtask

  task automatic run_load(input int wc, input logic [31:0] words[$], input int mode);
    int n;
    n = (wc > DEPTH) ? DEPTH : wc;
    clear_mon();
    start_load(wc);
    for (int i = 0; i < n; i++) begin
      send_word(words[i], mode);
      if (!is_legal(words[i][6:0]) && !exp_illegal) begin
        exp_illegal  = 1'b1;
        exp_ill_addr = ADDR_W'(i);
      end
    end
    for (int i = 0; i < 20 && done_cnt == 0; i++) tick();
    tick();
    tick();
    chk("done_pulses", 64'(done_cnt), 64'd1);
    chk("busy_after", 64'(busy), 64'd0);
    check_writes(n, words);
    chk("illegal", 64'(illegal), 64'(exp_illegal));
    chk("illegal_addr", 64'(illegal_addr), 64'(exp_ill_addr));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] words[$];
    logic [31:0] w0;
    logic [31:0] w1;
    int          wc;

    reset = 1'b1; start = 1'b0; word_count = '0; abort = 1'b0;
    byte_in = '0; byte_valid = 1'b0;
    repeat (3) tick();
    chk("rst_byte_ready", 64'(byte_ready), 64'd0);
    chk("rst_we", 64'(we), 64'd0);
    chk("rst_waddr", 64'(waddr), 64'd0);
    chk("rst_wdata", 64'(wdata), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_illegal", 64'(illegal), 64'd0);
    chk("rst_illegal_addr", 64'(illegal_addr), 64'd0);
    reset = 1'b0;
    tick();

    // Single word, back-to-back bytes, with cycle-exact write/done timing.
    clear_mon();
    start_load(1);
    chk("recv_byte_ready", 64'(byte_ready), 64'd1);
    send_word(32'h0000_2083, 0);
    chk("w1_we", 64'(we), 64'd1);
    chk("w1_waddr", 64'(waddr), 64'd0);
    chk("w1_wdata", 64'(wdata), 64'h0000_2083);
    chk("w1_byte_ready", 64'(byte_ready), 64'd0);
    tick();
    chk("w1_done", 64'(done), 64'd1);
    chk("w1_we_off", 64'(we), 64'd0);
    tick();
    chk("w1_done_off", 64'(done), 64'd0);
    chk("w1_busy_off", 64'(busy), 64'd0);
    chk("w1_we_count", 64'(wq_data.size()), 64'd1);
    chk("w1_illegal", 64'(illegal), 64'd0);

    // Three words with byte_valid toggling.
    words = '{32'h0000_2083, 32'h0011_2223, 32'h0020_8063};
    run_load(3, words, 1);

    // Two illegal words: only the first address is recorded.
    words = '{32'h0000_007F, 32'h0000_005B};
    run_load(2, words, 0);

    // Zero-length load: done one cycle after start, illegal state untouched.
    clear_mon();
    start_load(0);
    chk("wc0_done", 64'(done), 64'd1);
    chk("wc0_we", 64'(we), 64'd0);
    tick();
    chk("wc0_done_off", 64'(done), 64'd0);
    chk("wc0_we_count", 64'(wq_data.size()), 64'd0);
    chk("wc0_illegal_hold", 64'(illegal), 64'(exp_illegal));

    // Oversized count clamps to DEPTH.
    words.delete();
    for (int i = 0; i < DEPTH; i++) words.push_back(rand_word());
    run_load(100, words, 2);
    if (wq_addr.size() > 0) chk("clamp_last_waddr", 64'(wq_addr[$]), 64'(DEPTH - 1));
    else chk("clamp_last_waddr", 64'd0, 64'(DEPTH - 1));

    // Abort mid-word; a start pulse during the load must be ignored.
    w0 = 32'h0011_2223;
    w1 = 32'h0020_8063;
    clear_mon();
    start_load(2);
    send_byte(w0[7:0], 0);
    start = 1'b1; word_count = 7'd1;
    tick();
    start = 1'b0;
    send_byte(w0[15:8], 0);
    send_byte(w0[23:16], 0);
    send_byte(w0[31:24], 0);
    send_byte(w1[7:0], 1);
    send_byte(w1[15:8], 0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_byte_ready", 64'(byte_ready), 64'd0);
    repeat (4) tick();
    words = '{w0};
    check_writes(1, words);
    chk("abort_done", 64'(done_cnt), 64'd0);

    // Abort coinciding with WRITE suppresses the write strobe.
    clear_mon();
    start_load(3);
    send_word(32'h0000_0013, 0);
    abort = 1'b1;
    #1;
    chk("abort_wr_we", 64'(we), 64'd0);
    tick();
    abort = 1'b0;
    chk("abort_wr_busy", 64'(busy), 64'd0);
    repeat (3) tick();
    chk("abort_wr_we_count", 64'(wq_data.size()), 64'd0);
    chk("abort_wr_done", 64'(done_cnt), 64'd0);

    // Asynchronous reset between bytes 2 and 3.
    words = '{32'h0000_007F};
    run_load(1, words, 0);
    clear_mon();
    start_load(1);
    send_byte(8'h83, 0);
    send_byte(8'h20, 0);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_byte_ready", 64'(byte_ready), 64'd0);
    chk("arst_wdata", 64'(wdata), 64'd0);
    chk("arst_illegal", 64'(illegal), 64'd0);
    chk("arst_we", 64'(we), 64'd0);
    tick();
    reset = 1'b0;
    exp_illegal  = 1'b0;
    exp_ill_addr = '0;
    for (int i = 0; i < 8; i++) begin
      byte_valid = i[0];
      byte_in    = 8'($urandom);
      tick();
    end
    byte_valid = 1'b0;
    tick();
    chk("arst_no_we", 64'(wq_data.size()), 64'd0);
    chk("arst_no_done", 64'(done_cnt), 64'd0);

    // Randomised loads.
    for (int t = 0; t < 8; t++) begin
      wc = $urandom_range(1, 9);
      words.delete();
      for (int i = 0; i < wc; i++) words.push_back(rand_word());
      run_load(wc, words, 2);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/instr_loader.md
INSTR_LOADER -- requirements
Module: instr_loader

Interface
REQ-001 SHALL have parameter: DEPTH, 64, instruction memory depth in 32-bit words.
REQ-002 SHALL have parameter: ADDR_W, 6, word address width (log2 DEPTH).
REQ-003 SHALL have one clock and asynchronous active-high reset:
  clk  input  1  rising-edge clock, sole clock domain
  reset  input  1  asynchronous, active-high
REQ-004 SHALL have the remaining ports:
  start  input  1  one-cycle pulse, begin a load
  word_count  input  ADDR_W+1  words to load, sampled on start
  abort  input  1  synchronous cancel
  byte_in  input  8  instruction byte, little-endian order
  byte_valid  input  1  byte_in valid
  byte_ready  output  1  loader accepts a byte this cycle
  we  output  1  instruction memory write strobe
  waddr  output  ADDR_W  instruction memory word address
  wdata  output  32  assembled instruction word
  busy  output  1  high in any state other than IDLE
  done  output  1  one-cycle pulse, load complete
  illegal  output  1  sticky: unsupported opcode loaded
  illegal_addr  output  ADDR_W  word address of first illegal word

Function
REQ-005 SHALL implement FSM states IDLE, RECV, WRITE, DONE.
REQ-006 IDLE: start with word_count!=0 -> RECV, clearing byte index, word index, illegal and illegal_addr; start with word_count==0 -> DONE.
REQ-007 SHALL clamp a sampled word_count greater than DEPTH to DEPTH.
REQ-008 RECV: byte_ready=1; a byte is accepted only when byte_valid && byte_ready.
REQ-009 Accepted byte k (k=0..3) SHALL load wdata[8k+7:8k]; the first byte is the least-significant.
REQ-010 Acceptance of byte 3 SHALL move to WRITE; byte_ready SHALL be 0 in every state except RECV.
REQ-011 WRITE: we=1 for exactly one cycle with waddr = current word index and wdata = assembled word; latency is one cycle after the 4th handshake.
REQ-012 WRITE: legal opcodes are wdata[6:0] in {0x03, 0x23, 0x63, 0x33, 0x13}; any other value with illegal=0 SHALL set illegal=1 and illegal_addr=waddr; later illegal words SHALL NOT change illegal_addr.
REQ-013 Illegal words SHALL still be written; loading SHALL continue.
REQ-014 WRITE -> DONE when word index == word_count-1, otherwise -> RECV with the word index incremented and the byte index reset to 0.
REQ-015 DONE: done=1 for one cycle, then -> IDLE.
REQ-016 SHALL ignore start while busy=1.
REQ-017 abort in RECV or WRITE SHALL return to IDLE next cycle with no done pulse and the partial word discarded. An abort coinciding with WRITE suppresses we, and the abort takes priority over byte acceptance.
REQ-018 illegal and illegal_addr SHALL hold until the next accepted start or reset.
REQ-019 Word index SHALL never exceed DEPTH-1 (guaranteed by REQ-007); no wrap-around write.

Reset
REQ-020 Reset SHALL force state IDLE and drive byte_ready=0, we=0, waddr=0, wdata=0, busy=0, done=0, illegal=0, illegal_addr=0, counters 0.
REQ-021 Reset asserted mid-load SHALL take effect immediately (asynchronous) with no we or done afterwards.

Structure
REQ-022 Opcode constants (OP_LOAD 0x03, OP_STORE 0x23, OP_BRANCH 0x63, OP_RTYPE 0x33, OP_ITYPE 0x13) and the FSM state encoding SHALL live in shared package riscv_pkg, also used by control.
REQ-023 Opcode legality check SHALL be a sub-module opcode_check (combinational, 7-bit opcode in, legal out), reusable by control.

Verification
REQ-024 start, word_count=1; bytes 0x83,0x20,0x00,0x00 back-to-back -> one-cycle we with waddr=0, wdata=0x00002083, then done pulse; illegal=0.
REQ-025 word_count=3; words 0x00002083, 0x00112223, 0x00208063 with byte_valid toggling every other cycle -> we at waddr 0,1,2 with the matching data, exactly 3 we pulses, one done.
REQ-026 word_count=2; words 0x0000007F then 0x0000005B -> both written, illegal=1, illegal_addr=0.
REQ-027 word_count=0 -> done one cycle after start, no we; word_count=100 -> exactly 64 we pulses, last waddr=63.
REQ-028 word_count=2; abort after 2 bytes of word 1 -> IDLE, no we for word 1, no done; a second start during the load is ignored.
REQ-029 reset asserted between byte 2 and byte 3 -> all outputs 0 immediately; no we after release until a new start.
